axis_qrs_peak_detector: RTL and testbench

Adaptive-threshold QRS (R-peak) detector that sits directly downstream of the AXIS moving-average integrator in the ECG pipeline. Consumes one unsigned integrated-energy sample per AXI-Stream beat (~500 Hz), finds local maxima, and classifies each as signal or noise against a running Pan-Tompkins-style threshold. For each QRS after the first, it emits one AXI-Stream beat carrying the R-R interval in samples.

---
 rtl/axis_qrs_peak_detector.sv | 188 ++++++++++++++++++
 tb/tb_axis_qrs_peak_detector.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_qrs_peak_detector.sv
`default_nettype none
// ============================================================================
// Module   : axis_qrs_peak_detector
// Brief    : Adaptive-threshold R-peak detector on an AXIS integrated-energy
//            stream; emits the R-R interval (in samples) for each QRS after
//            the first.
// Revision : 1.0 - initial release
// ============================================================================
module axis_qrs_peak_detector #(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int LEARN_LEN  = 1000,
  parameter int REFRACTORY = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              ovf
);

  typedef enum logic [1:0] {
    S_LEARN   = 2'd0,
    S_DETECT  = 2'd1,
    S_REFRACT = 2'd2
  } state_t;

  localparam int c_LEARN_W = $clog2(LEARN_LEN + 1);
  localparam int c_REFR_W  = $clog2(REFRACTORY + 1);
  localparam logic [c_LEARN_W-1:0] c_LEARN_LAST = c_LEARN_W'(LEARN_LEN - 1);
  localparam logic [c_REFR_W-1:0]  c_REFR_LOAD  = c_REFR_W'(REFRACTORY);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_ready;
  logic [DATA_W-1:0]    r_x1, r_x2;
  logic [DATA_W-1:0]    r_spk, r_npk, r_max;
  logic [CNT_W-1:0]     r_cnt;
  logic [c_LEARN_W-1:0] r_learn_cnt;
  logic [c_REFR_W-1:0]  r_refr_cnt;
  logic                 r_have_ref;
  logic                 r_tvalid;
  logic [DATA_W-1:0]    r_tdata;
  logic                 r_ovf;

  logic                 w_acc;
  logic                 w_peak;
  logic [DATA_W-1:0]    w_thr;
  logic [DATA_W-1:0]    w_max_new;
  logic [DATA_W-1:0]    w_spk_upd, w_npk_upd;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [DATA_W-1:0]    w_interval;

  logic [DATA_W-1:0]    w_spk_nxt, w_npk_nxt, w_max_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [c_LEARN_W-1:0] w_learn_nxt;
  logic [c_REFR_W-1:0]  w_refr_nxt;
  logic                 w_have_ref_nxt;
  logic                 w_issue;

  assign w_acc      = s_axis_tvalid & r_ready;
  // x1 is the candidate; strict '>' against x2 keeps a plateau to one peak.
  assign w_peak     = (r_x1 > r_x2) && (r_x1 >= s_axis_tdata);
  assign w_thr      = (r_spk >= r_npk) ? (r_npk + ((r_spk - r_npk) >> 2)) : r_npk;
  assign w_max_new  = (s_axis_tdata > r_max) ? s_axis_tdata : r_max;
  assign w_spk_upd  = r_spk - (r_spk >> 3) + (r_x1 >> 3);
  assign w_npk_upd  = r_npk - (r_npk >> 3) + (r_x1 >> 3);
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  // The count before this sample's increment spans exactly peak-to-peak.
  assign w_interval = DATA_W'(r_cnt);

  always_comb begin
    w_state_nxt    = r_state;
    w_spk_nxt      = r_spk;
    w_npk_nxt      = r_npk;
    w_max_nxt      = r_max;
    w_cnt_nxt      = r_cnt;
    w_learn_nxt    = r_learn_cnt;
    w_refr_nxt     = r_refr_cnt;
    w_have_ref_nxt = r_have_ref;
    w_issue        = 1'b0;
    if (w_acc) begin
      case (r_state)
        S_LEARN: begin
          w_max_nxt = w_max_new;
          if (r_learn_cnt == c_LEARN_LAST) begin
            w_spk_nxt      = w_max_new >> 1;
            w_npk_nxt      = w_max_new >> 3;
            w_cnt_nxt      = '0;
            w_have_ref_nxt = 1'b0;
            w_state_nxt    = S_DETECT;
          end else begin
            w_learn_nxt = r_learn_cnt + c_LEARN_W'(1);
          end
        end
        S_DETECT: begin
          w_cnt_nxt = w_cnt_inc;
          if (w_peak) begin
            if (r_x1 > w_thr) begin
              w_spk_nxt      = w_spk_upd;
              w_issue        = r_have_ref;
              w_have_ref_nxt = 1'b1;
              w_cnt_nxt      = CNT_W'(1);
              w_refr_nxt     = c_REFR_LOAD;
              w_state_nxt    = S_REFRACT;
            end else begin
              w_npk_nxt = w_npk_upd;
            end
          end
        end
        S_REFRACT: begin
          w_cnt_nxt = w_cnt_inc;
          if (w_peak) begin
            w_npk_nxt = w_npk_upd;
          end
          if (r_refr_cnt <= c_REFR_W'(1)) begin
            w_refr_nxt  = '0;
            w_state_nxt = S_DETECT;
          end else begin
            w_refr_nxt = r_refr_cnt - c_REFR_W'(1);
          end
        end
        default: w_state_nxt = S_LEARN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LEARN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready     <= 1'b0;
      r_x1        <= '0;
      r_x2        <= '0;
      r_spk       <= '0;
      r_npk       <= '0;
      r_max       <= '0;
      r_cnt       <= '0;
      r_learn_cnt <= '0;
      r_refr_cnt  <= '0;
      r_have_ref  <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_ready     <= 1'b1;
      if (w_acc) begin
        r_x1 <= s_axis_tdata;
        r_x2 <= r_x1;
      end
      r_spk       <= w_spk_nxt;
      r_npk       <= w_npk_nxt;
      r_max       <= w_max_nxt;
      r_cnt       <= w_cnt_nxt;
      r_learn_cnt <= w_learn_nxt;
      r_refr_cnt  <= w_refr_nxt;
      r_have_ref  <= w_have_ref_nxt;
      // A still-blocked pending beat wins; the new interval is lost and flagged.
      if (w_issue) begin
        if (r_tvalid && !m_axis_tready) begin
          r_ovf <= 1'b1;
        end else begin
          r_tvalid <= 1'b1;
          r_tdata  <= w_interval;
        end
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign s_axis_tready = r_ready;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign ovf           = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_axis_qrs_peak_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_qrs_peak_detector
// Brief    : Scenario bench for the QRS peak detector with an R-R scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_qrs_peak_detector;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              ovf;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] exp_npk;

  axis_qrs_peak_detector #(
    .DATA_W(32), .CNT_W(16), .LEARN_LEN(1000), .REFRACTORY(100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .ovf           (ovf)
  );

  always #5 clk = ~clk;

  // Records every completed output beat for the scoreboard.
  always @(posedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [DATA_W-1:0] v);
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) send('0);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: no output may appear; 1: output val must appear one edge after the
  // 400 that follows the 800; 2: no latency check.
  task automatic pulse(input int mode, input logic [DATA_W-1:0] val);
    send(0); send(400); send(800); send(400);
    if (mode == 0) begin
      n_cmp++;
      if (m_axis_tvalid !== 1'b0) begin
        n_bad++;
        $display("FAIL pulse_no_output: tvalid=%b required 0", m_axis_tvalid);
      end
    end else if (mode == 1) begin
      exp_q.push_back(val);
      n_cmp++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== val) begin
        n_bad++;
        $display("FAIL pulse_latency: tvalid=%b tdata=%0d required tvalid=1 tdata=%0d",
                 m_axis_tvalid, m_axis_tdata, val);
      end
    end
    send(0);
  endtask

  task automatic period(input int mode, input logic [DATA_W-1:0] val);
    pulse(mode, val);
    zeros(245);
  endtask

  task automatic drain(input string name);
    idle(3);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s_count: got %0d beats required %0d", name, got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [DATA_W-1:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s_value: got %0d required %0d", name, g, e);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || ovf !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_outputs: tready=%b tvalid=%b tdata=%0d ovf=%b required all 0",
                 s_axis_tready, m_axis_tvalid, m_axis_tdata, ovf);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (s_axis_tready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_tready_early: tready=%b required 0", s_axis_tready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (s_axis_tready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_tready_rise: tready=%b required 1", s_axis_tready);
    end
  endtask

  task automatic test_learning();
    int highs;
    highs = 0;
    for (int i = 0; i < 1000; i++) begin
      send((i == 500) ? 32'd800 : 32'd0);
      if (m_axis_tvalid === 1'b1) highs++;
    end
    n_cmp++;
    if (highs != 0) begin
      n_bad++;
      $display("FAIL learn_no_output: tvalid high %0d cycles required 0", highs);
    end
    n_cmp++;
    if (dut.r_spk !== 32'd400 || dut.r_npk !== 32'd100 || dut.w_thr !== 32'd175) begin
      n_bad++;
      $display("FAIL learn_estimates: spk=%0d npk=%0d thr=%0d required 400 100 175",
               dut.r_spk, dut.r_npk, dut.w_thr);
    end
    exp_npk = 32'd100;
  endtask

  task automatic test_periodic();
    zeros(10);
    period(0, '0);
    for (int k = 0; k < 3; k++) period(1, 32'd250);
    drain("periodic");
  endtask

  task automatic test_refractory();
    pulse(1, 32'd250);
    zeros(47);
    send(800);
    send(0);
    exp_npk = exp_npk - (exp_npk >> 3) + (32'd800 >> 3);
    n_cmp++;
    if (dut.r_npk !== exp_npk || m_axis_tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL refract_noise: npk=%0d tvalid=%b required npk=%0d tvalid=0",
               dut.r_npk, m_axis_tvalid, exp_npk);
    end
    zeros(196);
    period(1, 32'd250);
    drain("refractory");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    m_axis_tready = 1'b0;
    period(1, 32'd250);
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd250 || ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_hold_first: tvalid=%b tdata=%0d ovf=%b required 1 250 0",
               m_axis_tvalid, m_axis_tdata, ovf);
    end
    period(2, '0);
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd250 || ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_drop_second: tvalid=%b tdata=%0d ovf=%b required 1 250 1",
               m_axis_tvalid, m_axis_tdata, ovf);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: tvalid=%b ovf=%b required 0 1", m_axis_tvalid, ovf);
    end
    drain("backpressure");
  endtask

  task automatic test_saturation();
    zeros(70000);
    pulse(1, 32'd65535);
    zeros(10);
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_ovf_sticky: ovf=%b required 1", ovf);
    end
    drain("saturation");
  endtask

  task automatic test_reset_mid();
    int highs;
    @(negedge clk);
    m_axis_tready = 1'b0;
    zeros(150);
    pulse(2, '0);
    n_cmp++;
    if (m_axis_tvalid !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_pending: tvalid=%b required 1", m_axis_tvalid);
    end
    send(0);
    send(400);
    @(negedge clk);
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || ovf !== 1'b0 || s_axis_tready !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_clear: tvalid=%b tdata=%0d ovf=%b tready=%b required all 0",
               m_axis_tvalid, m_axis_tdata, ovf, s_axis_tready);
    end
    @(negedge clk);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    highs = 0;
    for (int i = 0; i < 1000; i++) begin
      int ph;
      ph = i % 250;
      send((ph == 11 || ph == 13) ? 32'd400 : (ph == 12) ? 32'd800 : 32'd0);
      if (m_axis_tvalid === 1'b1) highs++;
    end
    n_cmp++;
    if (highs != 0) begin
      n_bad++;
      $display("FAIL rstmid_relearn_quiet: tvalid high %0d cycles required 0", highs);
    end
    n_cmp++;
    if (dut.r_spk !== 32'd400 || dut.r_npk !== 32'd100) begin
      n_bad++;
      $display("FAIL rstmid_relearn_est: spk=%0d npk=%0d required 400 100", dut.r_spk, dut.r_npk);
    end
    drain("rstmid");
  endtask

  initial begin
    test_reset();
    test_learning();
    test_periodic();
    test_refractory();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
